// File: rtl/button_press_classifier.sv
// button_press_classifier
//
// Takes the debounced, clk-synchronous button level and turns activity into
// single-cycle event pulses: press, release, short press, long press and
// double click. Durations are counted in strobes of an external tick
// timebase.
//
// Parameters
//   LONG_TICKS : ticks a press must be held to count as long (1 .. 2^CNT_W-1)
//   GAP_TICKS  : max ticks from first release to second press for a double
//                click (1 .. 2^CNT_W-1)
//   CNT_W      : width of the internal tick timer
//
// Ports
//   clk           : system clock, rising edge
//   reset         : synchronous, active-high reset
//   btn_in        : debounced button level, already synchronous to clk
//   tick          : timebase strobe, one clk wide
//   press_pulse   : one-cycle pulse per rising edge of btn_in
//   release_pulse : one-cycle pulse per falling edge of btn_in
//   short_press   : one-cycle pulse for a single short click
//   long_press    : one-cycle pulse when a hold reaches LONG_TICKS
//   double_click  : one-cycle pulse when the second short click releases
//   held          : high while a press is being tracked
//   event_count   : saturating count of short/long/double events
module button_press_classifier #(
    parameter int LONG_TICKS = 50,
    parameter int GAP_TICKS  = 25,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       tick,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       held,
    output logic [7:0] event_count
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_TICKS);

    // Adds 0..2 events to the counter, pinning at 255 instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic             btn_q;
    logic             rise_p0;
    logic             fall_p0;
    logic             tick_p0;
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_inc;

    assign timer_inc = timer + 1'b1;

    // Stage p0: edge detection. The tick strobe is delayed alongside the edge
    // flags so a tick and an edge that coincide on btn_in still coincide here.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q   <= 1'b0;
            rise_p0 <= 1'b0;
            fall_p0 <= 1'b0;
            tick_p0 <= 1'b0;
        end else begin
            btn_q   <= btn_in;
            rise_p0 <= btn_in & ~btn_q;
            fall_p0 <= ~btn_in & btn_q;
            tick_p0 <= tick;
        end
    end

    // Stage p1: classification FSM with registered outputs. Edges are tested
    // before the timer threshold, so an edge always wins a tie with a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
            held          <= 1'b0;
            event_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise_p0) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        timer       <= '0;
                        state       <= PRESSED;
                    end
                end

                PRESSED: begin
                    if (fall_p0) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        timer         <= '0;
                        state         <= WAIT_SECOND;
                    end else if (tick_p0) begin
                        if (timer_inc == LONG_LIM) begin
                            long_press  <= 1'b1;
                            event_count <= sat_add(event_count, 2'd1);
                            timer       <= '0;
                            state       <= LONG_HELD;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end

                LONG_HELD: begin
                    if (fall_p0) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        timer         <= '0;
                        state         <= IDLE;
                    end
                end

                WAIT_SECOND: begin
                    if (rise_p0) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        timer       <= '0;
                        state       <= SECOND_PRESSED;
                    end else if (tick_p0) begin
                        if (timer_inc == GAP_LIM) begin
                            short_press <= 1'b1;
                            event_count <= sat_add(event_count, 2'd1);
                            timer       <= '0;
                            state       <= IDLE;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end

                SECOND_PRESSED: begin
                    if (fall_p0) begin
                        release_pulse <= 1'b1;
                        double_click  <= 1'b1;
                        held          <= 1'b0;
                        event_count   <= sat_add(event_count, 2'd1);
                        timer         <= '0;
                        state         <= IDLE;
                    end else if (tick_p0) begin
                        if (timer_inc == LONG_LIM) begin
                            // The first click was short; report it together
                            // with the long hold of the second press.
                            short_press <= 1'b1;
                            long_press  <= 1'b1;
                            event_count <= sat_add(event_count, 2'd2);
                            timer       <= '0;
                            state       <= LONG_HELD;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end

                default: begin
                    held  <= 1'b0;
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
